// File: rtl/arm_mem_pkg.sv
// Shared memory-system constants and types for the data cache.
package arm_mem_pkg;

    localparam int unsigned MEM_BASE = 1024;
    localparam int unsigned WORD_W   = 32;
    localparam int unsigned LINE_W   = 64;
    localparam int unsigned SET_W    = 6;
    localparam int unsigned SETS     = 64;
    localparam int unsigned TAG_W    = 10;
    localparam int unsigned WAYS     = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2
    } cache_state_t;

endpackage

// File: rtl/cache_ram.sv
// Two-way cache storage: valid/tag/data per way, LRU bit per set.
// One synchronous write port, combinational read of both ways.
module cache_ram
    import arm_mem_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic [SET_W-1:0]             index,
    input  logic                         we,
    input  logic                         wr_way,
    input  logic [TAG_W-1:0]             wr_tag,
    input  logic [LINE_W-1:0]            wr_line,
    input  logic                         lru_we,
    input  logic                         lru_val,
    output logic [WAYS-1:0]              rd_valid,
    output logic [WAYS-1:0][TAG_W-1:0]   rd_tag,
    output logic [WAYS-1:0][LINE_W-1:0]  rd_data,
    output logic                         rd_lru
);

    logic [SETS-1:0]   valid_q [WAYS];
    logic [SETS-1:0]   lru_q;
    logic [TAG_W-1:0]  tag_mem  [WAYS][SETS];
    logic [LINE_W-1:0] data_mem [WAYS][SETS];

    // Valid and LRU state is cleared on reset; tags/data are not.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '{default: '0};
            lru_q   <= '0;
        end else begin
            if (we)
                valid_q[wr_way][index] <= 1'b1;
            if (lru_we)
                lru_q[index] <= lru_val;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            tag_mem[wr_way][index]  <= wr_tag;
            data_mem[wr_way][index] <= wr_line;
        end
    end

    always_comb begin
        for (int w = 0; w < int'(WAYS); w++) begin
            rd_valid[w] = valid_q[w][index];
            rd_tag[w]   = tag_mem[w][index];
            rd_data[w]  = data_mem[w][index];
        end
        rd_lru = lru_q[index];
    end

endmodule

// File: rtl/cache_controller.sv
// Write-through, no-write-allocate 2-way data cache between pipeline and SRAM controller.
// Read hits complete in the request cycle; misses fill a 64-bit line from SRAM.
module cache_controller #(
    parameter int unsigned MEM_BASE = arm_mem_pkg::MEM_BASE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MEM_R_EN,
    input  logic        MEM_W_EN,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        sram_r_en,
    output logic        sram_w_en,
    output logic [31:0] sram_address,
    output logic [31:0] sram_wdata,
    input  logic [63:0] sram_rdata,
    input  logic        sram_ready
);
    import arm_mem_pkg::*;

    cache_state_t state_q, state_d;

    logic [31:0]                  a;
    logic                         word_sel;
    logic [SET_W-1:0]             index;
    logic [TAG_W-1:0]             tag;
    logic                         unused_addr_bits;

    logic [WAYS-1:0]              rd_valid;
    logic [WAYS-1:0][TAG_W-1:0]   rd_tag;
    logic [WAYS-1:0][LINE_W-1:0]  rd_data;
    logic                         rd_lru;

    logic                         hit0, hit1, hit, hit_way, victim;
    logic [LINE_W-1:0]            hit_line, merged_line;
    logic [WORD_W-1:0]            hit_word, fill_word;

    logic                         ram_we, ram_way, lru_we;
    logic [LINE_W-1:0]            ram_line;

    assign a        = address - 32'(MEM_BASE);
    assign word_sel = a[2];
    assign index    = a[SET_W+2:3];
    assign tag      = a[TAG_W+SET_W+2:SET_W+3];
    assign unused_addr_bits = ^{a[31:TAG_W+SET_W+3], a[1:0]};

    // Lookup; a double hit cannot occur legally and resolves to way0.
    assign hit0     = rd_valid[0] && (rd_tag[0] == tag);
    assign hit1     = rd_valid[1] && (rd_tag[1] == tag);
    assign hit      = hit0 || hit1;
    assign hit_way  = !hit0;
    assign hit_line = rd_data[hit_way];
    assign hit_word = word_sel ? hit_line[63:32] : hit_line[31:0];
    assign fill_word = word_sel ? sram_rdata[63:32] : sram_rdata[31:0];
    assign victim   = !rd_valid[0] ? 1'b0 : (!rd_valid[1] ? 1'b1 : rd_lru);

    always_comb begin
        merged_line = hit_line;
        if (word_sel)
            merged_line[63:32] = wdata;
        else
            merged_line[31:0]  = wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        ready    = 1'b0;
        rdata    = '0;
        ram_we   = 1'b0;
        ram_way  = hit_way;
        ram_line = sram_rdata;
        lru_we   = 1'b0;
        case (state_q)
            IDLE: begin
                if (MEM_W_EN) begin
                    state_d = WRITE;
                end else if (MEM_R_EN) begin
                    if (hit) begin
                        ready  = 1'b1;
                        rdata  = hit_word;
                        lru_we = 1'b1;
                    end else begin
                        state_d = FILL;
                    end
                end else begin
                    ready = 1'b1;
                end
            end
            FILL: begin
                if (sram_ready) begin
                    ram_we  = 1'b1;
                    ram_way = victim;
                    lru_we  = 1'b1;
                    rdata   = fill_word;
                    ready   = 1'b1;
                    state_d = IDLE;
                end
            end
            WRITE: begin
                if (sram_ready) begin
                    ready   = 1'b1;
                    state_d = IDLE;
                    if (hit) begin
                        ram_we   = 1'b1;
                        ram_line = merged_line;
                        lru_we   = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign sram_r_en    = (state_q == FILL);
    assign sram_w_en    = (state_q == WRITE);
    assign sram_address = address;
    assign sram_wdata   = wdata;

    cache_ram u_ram (
        .clk      (clk),
        .rst      (rst),
        .index    (index),
        .we       (ram_we),
        .wr_way   (ram_way),
        .wr_tag   (tag),
        .wr_line  (ram_line),
        .lru_we   (lru_we),
        .lru_val  (!ram_way),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .rd_lru   (rd_lru)
    );

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller with a small SRAM word model and fixed-latency responder.
module tb_cache_controller;

    localparam int LAT = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        MEM_R_EN, MEM_W_EN;
    logic [31:0] address, wdata, rdata;
    logic        ready, sram_r_en, sram_w_en;
    logic [31:0] sram_address, sram_wdata;
    logic [63:0] sram_rdata;
    logic        sram_ready;

    int checks = 0;
    int errors = 0;
    logic [31:0] mem [logic [31:0]];

    cache_controller dut (
        .clk          (clk),
        .rst          (rst),
        .MEM_R_EN     (MEM_R_EN),
        .MEM_W_EN     (MEM_W_EN),
        .address      (address),
        .wdata        (wdata),
        .rdata        (rdata),
        .ready        (ready),
        .sram_r_en    (sram_r_en),
        .sram_w_en    (sram_w_en),
        .sram_address (sram_address),
        .sram_wdata   (sram_wdata),
        .sram_rdata   (sram_rdata),
        .sram_ready   (sram_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] addr);
        logic [31:0] wa;
        wa = {addr[31:2], 2'b00};
        if (mem.exists(wa))
            return mem[wa];
        return wa ^ 32'h5A5A_0000;
    endfunction

    // One pipeline access; exp_hit selects the expected read path.
    task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wd, input bit exp_hit, input string tag);
        logic [31:0] base;
        @(posedge clk); #1;
        MEM_R_EN = rd; MEM_W_EN = wr; address = addr; wdata = wd;
        @(negedge clk);
        if (wr) begin
            chk({tag, ".ready0"}, 64'(ready), 64'd0);
            for (int i = 0; i < LAT - 1; i++) begin
                @(negedge clk);
                chk({tag, ".wen"}, 64'(sram_w_en), 64'd1);
                chk({tag, ".ren"}, 64'(sram_r_en), 64'd0);
            end
            chk({tag, ".wdata"}, 64'(sram_wdata), 64'(wd));
            chk({tag, ".waddr"}, 64'(sram_address), 64'(addr));
            @(posedge clk); #1;
            sram_ready = 1'b1;
            @(negedge clk);
            chk({tag, ".ready"}, 64'(ready), 64'd1);
            mem[{addr[31:2], 2'b00}] = wd;
        end else if (exp_hit) begin
            chk({tag, ".ready"}, 64'(ready), 64'd1);
            chk({tag, ".rdata"}, 64'(rdata), 64'(mem_rd(addr)));
            chk({tag, ".ren"}, 64'(sram_r_en), 64'd0);
        end else begin
            chk({tag, ".ready0"}, 64'(ready), 64'd0);
            chk({tag, ".rdata0"}, 64'(rdata), 64'd0);
            for (int i = 0; i < LAT - 1; i++) begin
                @(negedge clk);
                chk({tag, ".ren"}, 64'(sram_r_en), 64'd1);
                chk({tag, ".rwait"}, 64'(ready), 64'd0);
            end
            base = {addr[31:3], 3'b000};
            @(posedge clk); #1;
            sram_ready = 1'b1;
            sram_rdata = {mem_rd(base + 32'd4), mem_rd(base)};
            @(negedge clk);
            chk({tag, ".ready"}, 64'(ready), 64'd1);
            chk({tag, ".rdata"}, 64'(rdata), 64'(mem_rd(addr)));
        end
        @(posedge clk); #1;
        MEM_R_EN = 1'b0; MEM_W_EN = 1'b0; sram_ready = 1'b0;
        sram_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("rst.ready", 64'(ready), 64'd1);
        chk("rst.ren", 64'(sram_r_en), 64'd0);
        chk("rst.wen", 64'(sram_w_en), 64'd0);
        chk("rst.rdata", 64'(rdata), 64'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; MEM_R_EN = 1'b0; MEM_W_EN = 1'b0;
        address = 32'h400; wdata = '0; sram_rdata = '0; sram_ready = 1'b0;
        mem[32'h400] = 32'h1111_1111;
        mem[32'h404] = 32'h2222_2222;
        do_reset();

        // Basic miss/hit on one line.
        access(1'b1, 1'b0, 32'h400, 32'h0, 1'b0, "rd400_miss");
        access(1'b1, 1'b0, 32'h404, 32'h0, 1'b1, "rd404_hit");

        // LRU replacement in set 0.
        access(1'b1, 1'b0, 32'h600, 32'h0, 1'b0, "rd600_miss");
        access(1'b1, 1'b0, 32'h800, 32'h0, 1'b0, "rd800_miss");
        access(1'b1, 1'b0, 32'h604, 32'h0, 1'b1, "rd604_hit");
        access(1'b1, 1'b0, 32'h400, 32'h0, 1'b0, "rd400_evicted");
        access(1'b1, 1'b0, 32'h600, 32'h0, 1'b1, "rd600_kept");
        access(1'b1, 1'b0, 32'h800, 32'h0, 1'b0, "rd800_evicted");

        // Last set, boundary of index field.
        access(1'b1, 1'b0, 32'h7F8, 32'h0, 1'b0, "rd7f8_miss");
        access(1'b1, 1'b0, 32'h7FC, 32'h0, 1'b1, "rd7fc_hit");

        // Write hit updates only the addressed word.
        access(1'b1, 1'b0, 32'h400, 32'h0, 1'b0, "rd400_refill");
        access(1'b0, 1'b1, 32'h404, 32'hDEAD_BEEF, 1'b0, "wr404");
        access(1'b1, 1'b0, 32'h404, 32'h0, 1'b1, "rd404_new");
        access(1'b1, 1'b0, 32'h400, 32'h0, 1'b1, "rd400_same");

        // Write miss does not allocate.
        access(1'b0, 1'b1, 32'hA00, 32'h1234_5678, 1'b0, "wrA00");
        access(1'b1, 1'b0, 32'hA00, 32'h0, 1'b0, "rdA00_miss");

        // Stray sram_ready in IDLE is ignored.
        @(posedge clk); #1;
        sram_ready = 1'b1; sram_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clk);
        chk("idle_sr.ready", 64'(ready), 64'd1);
        chk("idle_sr.ren", 64'(sram_r_en), 64'd0);
        @(posedge clk); #1;
        sram_ready = 1'b0;
        access(1'b1, 1'b0, 32'h404, 32'h0, 1'b1, "rd404_after_stray");

        // Reset during a fill abandons it.
        do_reset();
        @(posedge clk); #1;
        MEM_R_EN = 1'b1; address = 32'h400;
        repeat (2) @(negedge clk);
        chk("rstfill.ren", 64'(sram_r_en), 64'd1);
        @(posedge clk); #1;
        sram_ready = 1'b1; sram_rdata = 64'h0;
        rst = 1'b1;
        #1;
        chk("rstfill.ren_drop", 64'(sram_r_en), 64'd0);
        chk("rstfill.wen_drop", 64'(sram_w_en), 64'd0);
        MEM_R_EN = 1'b0; sram_ready = 1'b0;
        #1;
        chk("rstfill.ready", 64'(ready), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        access(1'b1, 1'b0, 32'h400, 32'h0, 1'b0, "rd400_after_rst");

        // Both enables high follows the write path.
        access(1'b1, 1'b1, 32'h400, 32'hCAFE_F00D, 1'b0, "both400");
        access(1'b1, 1'b0, 32'h400, 32'h0, 1'b1, "rd400_both");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
